// File: rtl/vdp_arb_pkg.sv
// Shared types and constants for the VRAM slot arbiter.
package vdp_arb_pkg;

  // Write-size codes presented on PRAM_WR_SIZE.
  typedef enum logic [1:0] {
    MEMORY_WIDTH_8  = 2'b00,
    MEMORY_WIDTH_16 = 2'b01,
    MEMORY_WIDTH_32 = 2'b10
  } mem_width_t;

  // Widest channel index supported (NUM_CH up to 8).
  localparam int unsigned MaxChW = 3;

  // grant_ch value meaning "display or idle"; consumers take the low CH_W+1 bits.
  localparam logic [MaxChW:0] GRANT_IDLE = '1;

  // Outcome of a slot decision.
  typedef enum logic [1:0] {
    OwnIdle = 2'b00,
    OwnDisp = 2'b01,
    OwnChan = 2'b10
  } slot_owner_t;

  // Dot phase on which the slot is decided, and the phase that ends a write strobe.
  localparam logic [1:0] DotSlot    = 2'b10;
  localparam logic [1:0] DotRelease = 2'b11;

endpackage

// File: rtl/vram_slot_arbiter_if.sv
// Requester-side bus: toggle handshake per channel plus tagged read return.
interface vram_slot_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*2-1:0]      ch_wsize;
  logic                     rd_valid;
  logic [CH_W-1:0]          rd_ch;
  logic [DATA_W-1:0]        rd_data;

  // Requesters drive requests and consume acks/read data.
  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata, ch_wsize,
    input  ch_ack, rd_valid, rd_ch, rd_data
  );

  // Arbiter side.
  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata, ch_wsize,
    output ch_ack, rd_valid, rd_ch, rd_data
  );
endinterface

// File: rtl/vram_rr_picker.sv
// Rotating priority encoder: first set bit of mask_i at or after ptr_i, wrapping.
module vram_rr_picker #(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   winner_o,
  output logic              found_o
);

  // Scan NUM_CH positions starting at the pointer; first hit wins.
  always_comb begin
    int unsigned idx;
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr_i) + k) % NUM_CH;
      if (!found_o && mask_i[idx]) begin
        found_o  = 1'b1;
        winner_o = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: one memory slot per dot to display fetch or a toggle-handshake channel.
module vram_slot_arbiter
  import vdp_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned MAX_WAIT = 15,
  localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic              CLK21M,
  input  logic              RESET_N,
  input  logic [1:0]        DOTSTATE,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  vram_slot_arbiter_if.slave bus,
  input  logic [DATA_W-1:0] vram_rd_data,
  output logic [ADDR_W-1:0] IRAMADR,
  output logic [DATA_W-1:0] PRAMDBO,
  output logic [1:0]        PRAM_WR_SIZE,
  output logic              PRAMWE_N,
  output logic [CH_W:0]     grant_ch
);

  localparam logic [CH_W:0] GntIdle = GRANT_IDLE[CH_W:0];
  localparam logic [3:0]    WaitMax = 4'(MAX_WAIT);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  mem_width_t        wsize_q, wsize_d;
  logic              we_n_q, we_n_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [CH_W:0]     grant_q, grant_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        wait_q [NUM_CH];
  logic [3:0]        wait_d [NUM_CH];
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [CH_W-1:0]   pipe_tag_q [RD_LAT];
  logic [CH_W-1:0]   pipe_tag_d [RD_LAT];
  logic              rd_valid_q, rd_valid_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [NUM_CH-1:0] pending;
  logic              starve_found;
  logic [CH_W-1:0]   starve_ch;
  logic              rr_found;
  logic [CH_W-1:0]   rr_win;
  slot_owner_t       own;
  logic [CH_W-1:0]   win;
  logic              rr_take;
  logic              push_vld;

  // A channel is pending while its request toggle differs from our ack toggle.
  assign pending = bus.ch_req ^ ack_q;

  // Channel 0 never takes part in round-robin; it has its own fixed priority.
  vram_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_rr_picker (
    .mask_i   ({pending[NUM_CH-1:1], 1'b0}),
    .ptr_i    (rr_ptr_q),
    .winner_o (rr_win),
    .found_o  (rr_found)
  );

  // Lowest-index pending channel whose wait counter has saturated.
  always_comb begin
    starve_found = 1'b0;
    starve_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i] && (wait_q[i] == WaitMax)) begin
        starve_found = 1'b1;
        starve_ch    = CH_W'(i);
      end
    end
  end

  // Slot owner selection in priority order: display, starved, CPU, round-robin.
  always_comb begin
    own     = OwnIdle;
    win     = '0;
    rr_take = 1'b0;
    if (disp_req) begin
      own = OwnDisp;
    end else if (starve_found) begin
      own = OwnChan;
      win = starve_ch;
    end else if (pending[0]) begin
      own = OwnChan;
    end else if (rr_found) begin
      own     = OwnChan;
      win     = rr_win;
      rr_take = 1'b1;
    end
  end

  // Next state of memory-side outputs, handshake, wait counters and RR pointer.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wsize_d  = wsize_q;
    we_n_d   = we_n_q;
    ack_d    = ack_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wait_d   = wait_q;
    push_vld = 1'b0;

    if (DOTSTATE == DotRelease) begin
      we_n_d = 1'b1;
    end

    if (DOTSTATE == DotSlot) begin
      grant_d = GntIdle;
      we_n_d  = 1'b1;
      // Every pending channel that loses this slot ages by one, saturating.
      for (int i = 0; i < NUM_CH; i++) begin
        if (pending[i] && !((own == OwnChan) && (int'(win) == i)) && (wait_q[i] != WaitMax)) begin
          wait_d[i] = wait_q[i] + 4'd1;
        end
      end
      unique case (own)
        OwnDisp: addr_d = disp_addr;
        OwnChan: begin
          addr_d       = bus.ch_addr[int'(win)*ADDR_W +: ADDR_W];
          ack_d[win]   = ~ack_q[win];
          wait_d[win]  = '0;
          grant_d      = {1'b0, win};
          if (bus.ch_we[win]) begin
            we_n_d  = 1'b0;
            wdata_d = bus.ch_wdata[int'(win)*DATA_W +: DATA_W];
            wsize_d = mem_width_t'(bus.ch_wsize[int'(win)*2 +: 2]);
          end else begin
            push_vld = 1'b1;
          end
          if (rr_take) begin
            if (int'(rr_win) + 1 >= int'(NUM_CH)) rr_ptr_d = CH_W'(1);
            else                                  rr_ptr_d = rr_win + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read-tag shift pipe; runs every cycle independent of later grants.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = push_vld;
    pipe_tag_d[0] = win;
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_tag_d[k] = pipe_tag_q[k-1];
    end
  end

  // Read return: capture memory data when a tag leaves the pipe.
  always_comb begin
    rd_valid_d = pipe_vld_q[RD_LAT-1];
    rd_ch_d    = rd_ch_q;
    rd_data_d  = rd_data_q;
    if (pipe_vld_q[RD_LAT-1]) begin
      rd_ch_d   = pipe_tag_q[RD_LAT-1];
      rd_data_d = vram_rd_data;
    end
  end

  // State registers; async reset also drops any in-flight read tags.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q     <= '1;
      wdata_q    <= '0;
      wsize_q    <= MEMORY_WIDTH_8;
      we_n_q     <= 1'b1;
      ack_q      <= '0;
      grant_q    <= GntIdle;
      rr_ptr_q   <= CH_W'(1);
      for (int i = 0; i < NUM_CH; i++) wait_q[i] <= '0;
      pipe_vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_tag_q[k] <= '0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wsize_q    <= wsize_d;
      we_n_q     <= we_n_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_q     <= wait_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
      rd_valid_q <= rd_valid_d;
      rd_ch_q    <= rd_ch_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign IRAMADR      = addr_q;
  assign PRAMDBO      = wdata_q;
  assign PRAM_WR_SIZE = wsize_q;
  assign PRAMWE_N     = we_n_q;
  assign grant_ch     = grant_q;
  assign bus.ch_ack   = ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_ch    = rd_ch_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: stimulus queues expectations, a monitor checks them.
module tb_vram_slot_arbiter;
  import vdp_arb_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    dotstate = 2'b00;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] vram_rd_data;
  logic [AW-1:0] iramadr;
  logic [DW-1:0] pramdbo;
  logic [1:0]    pram_wr_size;
  logic          pramwe_n;
  logic [2:0]    grant_ch;

  vram_slot_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_slot_arbiter #(
    .NUM_CH   (NCH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_LAT   (LAT),
    .MAX_WAIT (15)
  ) dut (
    .CLK21M       (clk),
    .RESET_N      (rst_n),
    .DOTSTATE     (dotstate),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .bus          (bus),
    .vram_rd_data (vram_rd_data),
    .IRAMADR      (iramadr),
    .PRAMDBO      (pramdbo),
    .PRAM_WR_SIZE (pram_wr_size),
    .PRAMWE_N     (pramwe_n),
    .grant_ch     (grant_ch)
  );

  always #5 clk = ~clk;

  // Memory model: one fixed word at 0x10000, otherwise address-derived data.
  assign vram_rd_data = (iramadr == 19'h10000) ? 32'hDEADBEEF : {iramadr[15:0], 16'h5A5A};

  typedef struct {
    logic [2:0]  gnt;
    logic [18:0] addr;
    logic        we_n;
    logic [3:0]  ack;
    logic [31:0] wd;
    logic [1:0]  ws;
    bit          chk_wr;
  } slot_exp_t;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  slot_exp_t  slot_q[$];
  rd_exp_t    rd_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [3:0] exp_ack = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: on each slot edge and each rd_valid pulse, pop and compare.
  initial begin
    logic [1:0] ds_at;
    logic       rst_at;
    slot_exp_t  e;
    rd_exp_t    r;
    forever begin
      @(posedge clk);
      cyc++;
      ds_at  = dotstate;
      rst_at = rst_n;
      @(negedge clk);
      if (rst_n && rst_at && ds_at == 2'b10) begin
        if (slot_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL slot_unexpected: grant_ch 0x%0h, no expectation queued", grant_ch);
        end else begin
          e = slot_q.pop_front();
          chk("grant_ch", 32'(grant_ch), 32'(e.gnt));
          chk("iramadr", 32'(iramadr), 32'(e.addr));
          chk("pramwe_n", 32'(pramwe_n), 32'(e.we_n));
          chk("ch_ack", 32'(bus.ch_ack), 32'(e.ack));
          if (e.chk_wr) begin
            chk("pramdbo", pramdbo, e.wd);
            chk("pram_wr_size", 32'(pram_wr_size), 32'(e.ws));
          end
        end
      end
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rd_unexpected: rd_ch %0d data 0x%0h, none expected", bus.rd_ch, bus.rd_data);
        end else begin
          r = rd_q.pop_front();
          chk("rd_ch", 32'(bus.rd_ch), 32'(r.ch));
          chk("rd_data", bus.rd_data, r.data);
          chk("rd_latency_cycle", 32'(cyc), 32'(r.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic [1:0] ds);
    dotstate = ds;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int ch, input bit we, input logic [18:0] a, input logic [31:0] wd,
                     input logic [1:0] ws);
    bus.ch_we[ch]           = we;
    bus.ch_addr[ch*AW +: AW] = a;
    bus.ch_wdata[ch*DW +: DW] = wd;
    bus.ch_wsize[ch*2 +: 2]  = ws;
    bus.ch_req[ch]          = ~bus.ch_req[ch];
  endtask

  // One dot; g = 7 means display/idle (no ack change).
  task automatic run_slot(input logic [2:0] g, input logic [18:0] a, input bit wr,
                          input logic [31:0] wd, input logic [1:0] ws, input bit rd,
                          input logic [31:0] rdat);
    slot_exp_t e;
    rd_exp_t   r;
    if (g != 3'h7) exp_ack[g[1:0]] = ~exp_ack[g[1:0]];
    e.gnt = g; e.addr = a; e.we_n = !wr; e.ack = exp_ack; e.wd = wd; e.ws = ws; e.chk_wr = wr;
    slot_q.push_back(e);
    step(2'b00);
    step(2'b01);
    step(2'b10);
    if (rd) begin
      r.ch = g[1:0]; r.data = rdat; r.due = cyc + LAT;
      rd_q.push_back(r);
    end
    step(2'b11);
    if (wr) chk("we_n_release", 32'(pramwe_n), 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iramadr"}, 32'(iramadr), 32'h7FFFF);
    chk({tag, "_pramdbo"}, pramdbo, 32'h0);
    chk({tag, "_wr_size"}, 32'(pram_wr_size), 32'h0);
    chk({tag, "_we_n"}, 32'(pramwe_n), 32'h1);
    chk({tag, "_ack"}, 32'(bus.ch_ack), 32'h0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
    chk({tag, "_rd_ch"}, 32'(bus.rd_ch), 32'h0);
    chk({tag, "_rd_data"}, bus.rd_data, 32'h0);
    chk({tag, "_grant"}, 32'(grant_ch), 32'h7);
  endtask

  initial begin
    bus.ch_req = '0; bus.ch_we = '0; bus.ch_addr = '0; bus.ch_wdata = '0; bus.ch_wsize = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // CPU write, then an idle slot that must hold the address.
    req(0, 1'b1, 19'h01234, 32'hA5, 2'b00);
    run_slot(3'd0, 19'h01234, 1'b1, 32'hA5, 2'b00, 1'b0, 32'h0);
    run_slot(3'd7, 19'h01234, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);

    // Round-robin 1,2,3,1 then CPU preempts a pending ch3.
    req(1, 1'b1, 19'h00101, 32'h11, 2'b01);
    req(2, 1'b1, 19'h00102, 32'h22, 2'b01);
    req(3, 1'b1, 19'h00103, 32'h33, 2'b01);
    run_slot(3'd1, 19'h00101, 1'b1, 32'h11, 2'b01, 1'b0, 32'h0);
    req(1, 1'b1, 19'h00111, 32'h1111, 2'b10);
    run_slot(3'd2, 19'h00102, 1'b1, 32'h22, 2'b01, 1'b0, 32'h0);
    run_slot(3'd3, 19'h00103, 1'b1, 32'h33, 2'b01, 1'b0, 32'h0);
    run_slot(3'd1, 19'h00111, 1'b1, 32'h1111, 2'b10, 1'b0, 32'h0);
    req(3, 1'b1, 19'h00133, 32'h3333, 2'b00);
    req(0, 1'b1, 19'h00100, 32'h0F, 2'b01);
    run_slot(3'd0, 19'h00100, 1'b1, 32'h0F, 2'b01, 1'b0, 32'h0);
    run_slot(3'd3, 19'h00133, 1'b1, 32'h3333, 2'b00, 1'b0, 32'h0);

    // Back-to-back reads with tagged return.
    req(1, 1'b0, 19'h10000, 32'h0, 2'b00);
    run_slot(3'd1, 19'h10000, 1'b0, 32'h0, 2'b00, 1'b1, 32'hDEADBEEF);
    req(2, 1'b0, 19'h00042, 32'h0, 2'b00);
    run_slot(3'd2, 19'h00042, 1'b0, 32'h0, 2'b00, 1'b1, 32'h00425A5A);

    // Starvation: ch2 loses 17 display slots (counter saturates), then beats a fresh ch0.
    req(2, 1'b1, 19'h00222, 32'h12345678, 2'b10);
    disp_req = 1'b1;
    for (int k = 0; k < 17; k++) begin
      disp_addr = 19'h40000 + 19'(k);
      run_slot(3'd7, disp_addr, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    end
    disp_req = 1'b0;
    req(0, 1'b1, 19'h00200, 32'hFF, 2'b01);
    run_slot(3'd2, 19'h00222, 1'b1, 32'h12345678, 2'b10, 1'b0, 32'h0);
    run_slot(3'd0, 19'h00200, 1'b1, 32'hFF, 2'b01, 1'b0, 32'h0);

    // Display owns the slot even with every channel pending; then CPU, then RR from ptr 3.
    for (int c = 0; c < 4; c++) req(c, 1'b1, 19'h0A000 + 19'(c), 32'hC0 + 32'(c), 2'b00);
    disp_req  = 1'b1;
    disp_addr = 19'h55555;
    run_slot(3'd7, 19'h55555, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    disp_req = 1'b0;
    run_slot(3'd0, 19'h0A000, 1'b1, 32'hC0, 2'b00, 1'b0, 32'h0);
    run_slot(3'd3, 19'h0A003, 1'b1, 32'hC3, 2'b00, 1'b0, 32'h0);
    run_slot(3'd1, 19'h0A001, 1'b1, 32'hC1, 2'b00, 1'b0, 32'h0);
    run_slot(3'd2, 19'h0A002, 1'b1, 32'hC2, 2'b00, 1'b0, 32'h0);

    // Reset shortly after a read grant: the read must never return.
    req(1, 1'b0, 19'h10000, 32'h0, 2'b00);
    begin
      slot_exp_t e;
      exp_ack[1] = ~exp_ack[1];
      e.gnt = 3'd1; e.addr = 19'h10000; e.we_n = 1'b1; e.ack = exp_ack;
      e.wd = '0; e.ws = '0; e.chk_wr = 1'b0;
      slot_q.push_back(e);
    end
    step(2'b00);
    step(2'b01);
    step(2'b10);
    #5;
    rst_n    = 1'b0;
    dotstate = 2'b00;
    bus.ch_req = '0;
    exp_ack  = '0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(2'b00);
    chk_reset_outputs("postrst");

    // Round-robin pointer is back at 1 after reset.
    req(2, 1'b1, 19'h00302, 32'h32, 2'b00);
    req(1, 1'b1, 19'h00301, 32'h31, 2'b00);
    run_slot(3'd1, 19'h00301, 1'b1, 32'h31, 2'b00, 1'b0, 32'h0);
    run_slot(3'd2, 19'h00302, 1'b1, 32'h32, 2'b00, 1'b0, 32'h0);

    repeat (6) step(2'b00);
    chk("slot_queue_left", 32'(slot_q.size()), 32'h0);
    chk("rd_queue_left", 32'(rd_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
